// File: rtl/medio_sumador_sync.sv
// Multi-lane clocked half adder: per-lane sum/carry with registered outputs,
// a valid qualifier, and a saturating tally of cycles that produced any carry.
module medio_sumador_sync #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Cout,
    output logic [WIDTH-1:0] S_comb,
    output logic [WIDTH-1:0] Cout_comb,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] cout_q, cout_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign S_comb    = A ^ B;
    assign Cout_comb = A & B;

    always_comb begin
        s_d     = s_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        cnt_d   = cnt_q;
        if (in_valid) begin
            s_d    = S_comb;
            cout_d = Cout_comb;
        end
        // Clear beats increment; one count per cycle no matter how many lanes carry.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_valid && (|Cout_comb) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            cout_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;
    assign carry_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_medio_sumador_sync.sv
// Bench for medio_sumador_sync: a 4-lane/2-bit-counter instance and a
// 1-lane/8-bit-counter instance driven together against an arithmetic model.
module tb_medio_sumador_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       cnt_clr;
    logic [3:0] a4, b4;

    logic       ov4, ov1;
    logic [3:0] s4, c4, sc4, cc4;
    logic [0:0] s1, c1, sc1, cc1;
    logic [1:0] cnt4;
    logic [7:0] cnt1;
    logic       sat4, sat1;

    int n_chk  = 0;
    int n_fail = 0;

    // reference state
    logic [3:0] e_s4, e_c4;
    logic       e_s1, e_c1, e_v;
    int         e_cnt4, e_cnt1;

    always #5 clk = ~clk;

    medio_sumador_sync #(.WIDTH(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a4), .B(b4), .cnt_clr(cnt_clr),
        .out_valid(ov4), .S(s4), .Cout(c4), .S_comb(sc4), .Cout_comb(cc4),
        .carry_cnt(cnt4), .cnt_sat(sat4)
    );

    medio_sumador_sync #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a4[0]), .B(b4[0]), .cnt_clr(cnt_clr),
        .out_valid(ov1), .S(s1), .Cout(c1), .S_comb(sc1), .Cout_comb(cc1),
        .carry_cnt(cnt1), .cnt_sat(sat1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Half add computed as integer sum of two bits: low digit is S, high digit is Cout.
    function automatic void ref_add(input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] s, output logic [3:0] c);
        for (int i = 0; i < 4; i++) begin
            int t;
            t = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) != 0;
            c[i] = (t / 2) != 0;
        end
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".ov4"},  32'(ov4),  32'(e_v));
        check({tag, ".ov1"},  32'(ov1),  32'(e_v));
        check({tag, ".s4"},   32'(s4),   32'(e_s4));
        check({tag, ".c4"},   32'(c4),   32'(e_c4));
        check({tag, ".s1"},   32'(s1),   32'(e_s1));
        check({tag, ".c1"},   32'(c1),   32'(e_c1));
        check({tag, ".cnt4"}, 32'(cnt4), 32'(e_cnt4));
        check({tag, ".cnt1"}, 32'(cnt1), 32'(e_cnt1));
        check({tag, ".sat4"}, 32'(sat4), 32'(e_cnt4 == 3));
        check({tag, ".sat1"}, 32'(sat1), 32'(e_cnt1 == 255));
    endtask

    task automatic model_reset();
        e_s4 = '0; e_c4 = '0; e_s1 = 1'b0; e_c1 = 1'b0; e_v = 1'b0;
        e_cnt4 = 0; e_cnt1 = 0;
    endtask

    // Starts and ends just after a falling edge.
    task automatic cycle(input string tag, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic clr);
        logic [3:0] ps, pc;
        in_valid = v; a4 = a; b4 = b; cnt_clr = clr;
        ref_add(a, b, ps, pc);
        #1;
        check({tag, ".sc4"}, 32'(sc4), 32'(ps));
        check({tag, ".cc4"}, 32'(cc4), 32'(pc));
        check({tag, ".sc1"}, 32'(sc1), 32'(ps[0]));
        check({tag, ".cc1"}, 32'(cc1), 32'(pc[0]));
        @(posedge clk);
        e_v = v;
        if (v) begin
            e_s4 = ps; e_c4 = pc; e_s1 = ps[0]; e_c1 = pc[0];
        end
        if (clr) begin
            e_cnt4 = 0; e_cnt1 = 0;
        end else if (v) begin
            if (pc != 0 && e_cnt4 < 3)    e_cnt4++;
            if (pc[0] && e_cnt1 < 255)    e_cnt1++;
        end
        @(negedge clk);
        check_regs(tag);
    endtask

    // Pulse reset between edges and look at outputs before any clock edge.
    task automatic reset_pulse(input string tag);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_regs(tag);
        check({tag, ".sc4_track"}, 32'(sc4), 32'(a4 ^ b4));
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; a4 = '0; b4 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_regs("rst");
        rst = 1'b0;

        cycle("tt00", 1'b1, 4'b0000, 4'b0000, 1'b0);
        cycle("tt01", 1'b1, 4'b0000, 4'b0001, 1'b0);
        cycle("tt10", 1'b1, 4'b0001, 4'b0000, 1'b0);
        cycle("tt11", 1'b1, 4'b0001, 4'b0001, 1'b0);
        cycle("gate", 1'b0, 4'b1111, 4'b1111, 1'b0);
        cycle("lane", 1'b1, 4'b1100, 4'b1010, 1'b0);

        cycle("sclr", 1'b1, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) cycle("sat", 1'b1, 4'b1111, 4'b1111, 1'b0);
        cycle("clrpri", 1'b1, 4'b1111, 4'b1111, 1'b1);

        cycle("pre_rst", 1'b1, 4'b0101, 4'b0011, 1'b0);
        reset_pulse("arst");
        cycle("post_rst", 1'b0, 4'b1111, 4'b0000, 1'b0);
        cycle("post_rst2", 1'b1, 4'b1001, 4'b1011, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic       v, clr;
            logic [3:0] a, b;
            v   = ($urandom % 4) != 0;
            clr = ($urandom % 24) == 0;
            a   = 4'($urandom);
            b   = 4'($urandom);
            cycle("rnd", v, a, b, clr);
            if (i == 150) reset_pulse("arst_rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
